// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 8-way
// round-robin arbiter.
package rr_arbiter_8_pkg;

    localparam int unsigned ARB_N        = 8;
    localparam int unsigned ARB_IDXW     = 3;
    localparam int unsigned ARB_MAX_HOLD = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [ARB_N-1:0] arb_onehot(input logic [ARB_IDXW-1:0] idx);
        logic [ARB_N-1:0] one;
        one        = 8'h01;
        arb_onehot = one << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
    import rr_arbiter_8_pkg::*;

    logic [ARB_N-1:0]    req;
    logic                done;
    logic [ARB_N-1:0]    gnt;
    logic [ARB_IDXW-1:0] gnt_idx;
    logic                gnt_valid;
    logic                timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_arbiter_8_chk.sv
// Structural checks on the grant outputs: never multi-hot, index matches
// the one-hot grant, valid mirrors the OR of the grant.
module rr_arbiter_8_chk
    import rr_arbiter_8_pkg::*;
(
    input logic                clk,
    input logic                rst,
    input logic [ARB_N-1:0]    gnt,
    input logic [ARB_IDXW-1:0] gnt_idx,
    input logic                gnt_valid
);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    a_gnt_idx_enc: assert property (@(posedge clk) disable iff (rst)
        gnt_valid |-> (gnt == arb_onehot(gnt_idx)));

    a_gnt_valid_or: assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));

endmodule

// File: rtl/rr_arbiter_8_pick.sv
// Combinational round-robin winner select: the first set request found
// searching upward from ptr+1, wrapping 7 -> 0.
module rr_pick8
    import rr_arbiter_8_pkg::*;
(
    input  logic [ARB_N-1:0]    req,
    input  logic [ARB_IDXW-1:0] ptr,
    output logic [ARB_IDXW-1:0] win,
    output logic                any
);

    logic [ARB_IDXW-1:0] start_s;
    logic [ARB_N-1:0]    rot_s;
    logic [ARB_IDXW-1:0] ofs_s;

    // Rotate so the highest-priority requester sits at bit 0, then find the lowest set bit.
    always_comb begin
        start_s = ptr + 3'd1;
        rot_s   = 8'h00;
        ofs_s   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            rot_s[i] = req[start_s + 3'(i)];
        end
        for (int i = 7; i >= 0; i--) begin
            ofs_s = rot_s[i] ? 3'(i) : ofs_s;
        end
        win = start_s + ofs_s;
        any = |req;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered one-hot grant, binary
// index, owner release via done/req drop, and an optional hold timeout.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
)
(
    input logic           clk,
    input logic           rst,
    rr_arbiter_8_if.slave bus
);

    localparam int unsigned HOLDW = (MAX_HOLD > 32'd1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLDW-1:0] HOLD_LAST =
        (MAX_HOLD > 32'd0) ? HOLDW'(MAX_HOLD - 32'd1) : {HOLDW{1'b1}};

    arb_state_e          state_r,   state_nx_s;
    logic [ARB_IDXW-1:0] ptr_r,     ptr_nx_s;
    logic [HOLDW-1:0]    hold_r,    hold_nx_s;
    logic [ARB_N-1:0]    gnt_r,     gnt_nx_s;
    logic [ARB_IDXW-1:0] idx_r,     idx_nx_s;
    logic                valid_r,   valid_nx_s;
    logic                timeout_r, timeout_nx_s;

    logic [ARB_IDXW-1:0] win_s;
    logic                any_s;
    logic                rel_done_s;
    logic                rel_drop_s;
    logic                rel_to_s;

    rr_pick8 u_pick (
        .req (bus.req),
        .ptr (ptr_r),
        .win (win_s),
        .any (any_s)
    );

    assign rel_done_s = bus.done;
    assign rel_drop_s = ~bus.req[idx_r];
    assign rel_to_s   = (MAX_HOLD != 32'd0) && (hold_r == HOLD_LAST);

    // Next-state and next-output logic; IDLE always sits between two grants.
    always_comb begin
        state_nx_s   = state_r;
        ptr_nx_s     = ptr_r;
        hold_nx_s    = hold_r;
        gnt_nx_s     = gnt_r;
        idx_nx_s     = idx_r;
        valid_nx_s   = valid_r;
        timeout_nx_s = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (any_s) begin
                    state_nx_s = ARB_GRANT;
                    gnt_nx_s   = arb_onehot(win_s);
                    idx_nx_s   = win_s;
                    valid_nx_s = 1'b1;
                    ptr_nx_s   = win_s;
                    hold_nx_s  = {HOLDW{1'b0}};
                end else begin
                    gnt_nx_s   = 8'h00;
                    valid_nx_s = 1'b0;
                end
            end
            ARB_GRANT: begin
                if (rel_done_s || rel_drop_s || rel_to_s) begin
                    state_nx_s   = ARB_IDLE;
                    gnt_nx_s     = 8'h00;
                    valid_nx_s   = 1'b0;
                    hold_nx_s    = {HOLDW{1'b0}};
                    // Flag a timeout only when expiry alone forced the release.
                    timeout_nx_s = rel_to_s && !rel_done_s && !rel_drop_s;
                end else begin
                    hold_nx_s = (hold_r == HOLD_LAST) ? hold_r : hold_r + HOLDW'(1);
                end
            end
            default: begin
                state_nx_s = ARB_IDLE;
                gnt_nx_s   = 8'h00;
                valid_nx_s = 1'b0;
                hold_nx_s  = {HOLDW{1'b0}};
            end
        endcase
    end

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ARB_IDLE;
            ptr_r     <= 3'd7;
            hold_r    <= {HOLDW{1'b0}};
            gnt_r     <= 8'h00;
            idx_r     <= 3'd0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            ptr_r     <= ptr_nx_s;
            hold_r    <= hold_nx_s;
            gnt_r     <= gnt_nx_s;
            idx_r     <= idx_nx_s;
            valid_r   <= valid_nx_s;
            timeout_r <= timeout_nx_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_idx   = idx_r;
    assign bus.gnt_valid = valid_r;
    assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: expected grant state is queued as each
// step is driven and checked one edge later; grant invariants checked every cycle.
module tb_rr_arbiter_8;

    typedef struct {
        string      tag;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    logic clk;
    logic rst;
    rr_arbiter_8_if bus ();

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    rr_arbiter_8 #(.MAX_HOLD(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rr_arbiter_8_chk chk (
        .clk       (clk),
        .rst       (rst),
        .gnt       (bus.gnt),
        .gnt_idx   (bus.gnt_idx),
        .gnt_valid (bus.gnt_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] oh(input int i);
        logic [7:0] one;
        one = 8'h01;
        return one << i;
    endfunction

    function automatic logic [2:0] enc(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Queue the expectation, advance one edge, then pop and compare.
    task automatic exp_step(input string tag, input logic [7:0] g, input logic [2:0] idx,
                            input logic v, input logic to);
        exp_t e;
        e.tag = tag; e.gnt = g; e.idx = idx; e.valid = v; e.to = to;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_cmp++;
        assert ({bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout} === {e.gnt, e.idx, e.valid, e.to})
        else begin
            n_bad++;
            $error("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, expected gnt=%h idx=%0d valid=%b timeout=%b",
                   e.tag, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, e.gnt, e.idx, e.valid, e.to);
        end
    endtask

    // Per-cycle structural invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_cmp++;
            assert ($onehot0(bus.gnt)) else begin
                n_bad++;
                $error("FAIL onehot0: got gnt=%h, expected zero or one-hot", bus.gnt);
            end
            n_cmp++;
            assert (bus.gnt_valid === (|bus.gnt)) else begin
                n_bad++;
                $error("FAIL valid_or: got gnt_valid=%b, expected %b", bus.gnt_valid, |bus.gnt);
            end
            if (bus.gnt_valid === 1'b1) begin
                n_cmp++;
                assert (bus.gnt_idx === enc(bus.gnt)) else begin
                    n_bad++;
                    $error("FAIL idx_enc: got gnt_idx=%0d, expected %0d", bus.gnt_idx, enc(bus.gnt));
                end
            end
        end
    end

    initial begin
        logic [2:0] k;
        rst      = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;

        // Reset state, then first grant to requester 0.
        exp_step("rst_a", 8'h00, 3'd0, 1'b0, 1'b0);
        exp_step("rst_b", 8'h00, 3'd0, 1'b0, 1'b0);
        rst     = 1'b0;
        bus.req = 8'h01;
        exp_step("t1_gnt0", 8'h01, 3'd0, 1'b1, 1'b0);
        bus.req = 8'h00;
        exp_step("t1_drop", 8'h00, 3'd0, 1'b0, 1'b0);

        // All requesting: rotation 0..7,0 with a gap cycle between grants.
        rst = 1'b1;
        exp_step("t2_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst     = 1'b0;
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            k = 3'(i % 8);
            exp_step("t2_gnt", oh(int'(k)), k, 1'b1, 1'b0);
            exp_step("t2_hold", oh(int'(k)), k, 1'b1, 1'b0);
            bus.done = 1'b1;
            exp_step("t2_gap", 8'h00, k, 1'b0, 1'b0);
            bus.done = 1'b0;
        end
        bus.req = 8'h00;
        exp_step("t2_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Wrap past 6,7 from ptr=5, then back to 5.
        bus.req = 8'h20;
        exp_step("t3_g5", 8'h20, 3'd5, 1'b1, 1'b0);
        bus.req  = 8'h21;
        bus.done = 1'b1;
        exp_step("t3_rel5", 8'h00, 3'd5, 1'b0, 1'b0);
        bus.done = 1'b0;
        exp_step("t3_wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
        bus.done = 1'b1;
        exp_step("t3_rel0", 8'h00, 3'd0, 1'b0, 1'b0);
        bus.done = 1'b0;
        exp_step("t3_g5b", 8'h20, 3'd5, 1'b1, 1'b0);
        bus.req = 8'h00;
        exp_step("t3_drop", 8'h00, 3'd5, 1'b0, 1'b0);

        // Hold timeout: 16 granted cycles, one timeout pulse, regrant.
        bus.req = 8'h08;
        exp_step("t4_g3", 8'h08, 3'd3, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) exp_step("t4_hold", 8'h08, 3'd3, 1'b1, 1'b0);
        exp_step("t4_timeout", 8'h00, 3'd3, 1'b0, 1'b1);
        exp_step("t4_regnt", 8'h08, 3'd3, 1'b1, 1'b0);

        // done coinciding with expiry is a normal release.
        for (int i = 0; i < 15; i++) exp_step("t6_hold", 8'h08, 3'd3, 1'b1, 1'b0);
        bus.done = 1'b1;
        exp_step("t6_done_to", 8'h00, 3'd3, 1'b0, 1'b0);
        bus.done = 1'b0;
        exp_step("t6_g3", 8'h08, 3'd3, 1'b1, 1'b0);
        bus.req = 8'h00;
        exp_step("t6_drop", 8'h00, 3'd3, 1'b0, 1'b0);

        // Reset mid-grant restores ptr=7, so 8'h90 goes to requester 4.
        bus.req = 8'h10;
        exp_step("t5_g4", 8'h10, 3'd4, 1'b1, 1'b0);
        rst = 1'b1;
        exp_step("t5_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst     = 1'b0;
        bus.req = 8'h90;
        exp_step("t5_g4b", 8'h10, 3'd4, 1'b1, 1'b0);
        bus.done = 1'b1;
        exp_step("t5_rel", 8'h00, 3'd4, 1'b0, 1'b0);
        bus.req = 8'h00;
        exp_step("t5_idle_done", 8'h00, 3'd4, 1'b0, 1'b0);
        bus.done = 1'b0;
        exp_step("t5_idle", 8'h00, 3'd4, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
